// File: rtl/pipeline_control_if.sv
// pipeline_control_if
//   Groups the hazard-detection inputs and the pipeline control outputs of
//   the five-stage pipeline hazard/sequencing controller.
//   master : datapath side. It drives the hazard inputs and receives the
//            control outputs.
//   slave  : controller side (pipeline_control).
//   Hazard inputs   : idExMemRead, idExRt, ifIdRs, ifIdRt, ifIdUsesRt, jump,
//                     branchTaken, memReq, memReady
//   Control outputs : pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeFreeze,
//                     busError, ctrlState, stallCount
interface pipeline_control_if;
    logic        idExMemRead;
    logic [4:0]  idExRt;
    logic [4:0]  ifIdRs;
    logic [4:0]  ifIdRt;
    logic        ifIdUsesRt;
    logic        jump;
    logic        branchTaken;
    logic        memReq;
    logic        memReady;

    logic        pcWrite;
    logic        ifIdWrite;
    logic        ifIdFlush;
    logic        idExFlush;
    logic        pipeFreeze;
    logic        busError;
    logic [1:0]  ctrlState;
    logic [15:0] stallCount;

    modport master (
        output idExMemRead, idExRt, ifIdRs, ifIdRt, ifIdUsesRt,
               jump, branchTaken, memReq, memReady,
        input  pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeFreeze,
               busError, ctrlState, stallCount
    );

    modport slave (
        input  idExMemRead, idExRt, ifIdRs, ifIdRt, ifIdUsesRt,
               jump, branchTaken, memReq, memReady,
        output pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeFreeze,
               busError, ctrlState, stallCount
    );
endinterface

// File: rtl/pipeline_control.sv
// pipeline_control
//   Hazard and sequencing controller for the five-stage pipeline. It handles
//   load-use stalls, branch/jump flushes, and multi-cycle data-memory waits.
//   A memory-wait watchdog drives a sticky error state, and a saturating
//   counter tracks stall cycles.
//   Parameter : TIMEOUT - maximum consecutive MEM_WAIT cycles (1..65535)
//   Ports     : clock  - rising-edge pipeline clock
//               reset  - asynchronous, active-low
//               bus    - pipeline_control_if.slave (hazard inputs, controls)
module pipeline_control #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    pipeline_control_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state, stateNext;
    logic [15:0] waitCnt, waitCntNext;
    logic [15:0] stallCnt;

    logic loadUse;
    logic lpPcWrite, lpIfIdWrite, lpIfIdFlush, lpIdExFlush;
    logic pcWriteC, ifIdWriteC, ifIdFlushC, idExFlushC, pipeFreezeC, busErrorC;

    // Lower-priority hazard decode shared by RUN and the MEM_WAIT release cycle.
    always_comb begin
        loadUse = bus.idExMemRead && (bus.idExRt != 5'd0) &&
                  ((bus.idExRt == bus.ifIdRs) ||
                   (bus.ifIdUsesRt && (bus.idExRt == bus.ifIdRt)));
        lpPcWrite   = 1'b1;
        lpIfIdWrite = 1'b1;
        lpIfIdFlush = 1'b0;
        lpIdExFlush = 1'b0;
        if (bus.branchTaken) begin
            lpIfIdFlush = 1'b1;
            lpIdExFlush = 1'b1;
        end else if (loadUse) begin
            lpPcWrite   = 1'b0;
            lpIfIdWrite = 1'b0;
            lpIdExFlush = 1'b1;
        end else if (bus.jump) begin
            lpIfIdFlush = 1'b1;
        end
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        pcWriteC    = lpPcWrite;
        ifIdWriteC  = lpIfIdWrite;
        ifIdFlushC  = lpIfIdFlush;
        idExFlushC  = lpIdExFlush;
        pipeFreezeC = 1'b0;
        busErrorC   = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.memReq && !bus.memReady) begin
                    pcWriteC    = 1'b0;
                    ifIdWriteC  = 1'b0;
                    ifIdFlushC  = 1'b0;
                    idExFlushC  = 1'b0;
                    pipeFreezeC = 1'b1;
                    stateNext   = MEM_WAIT;
                    waitCntNext = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (!bus.memReady) begin
                    pcWriteC    = 1'b0;
                    ifIdWriteC  = 1'b0;
                    ifIdFlushC  = 1'b0;
                    idExFlushC  = 1'b0;
                    pipeFreezeC = 1'b1;
                    if (waitCnt >= TIMEOUT_W) begin
                        stateNext = ERROR;
                    end else begin
                        waitCntNext = waitCnt + 16'd1;
                    end
                end else begin
                    // Stage contents were held by the freeze, so the release
                    // cycle resolves the hazards that built up during the wait.
                    stateNext   = RUN;
                    waitCntNext = '0;
                end
            end
            ERROR: begin
                pcWriteC    = 1'b0;
                ifIdWriteC  = 1'b0;
                ifIdFlushC  = 1'b0;
                idExFlushC  = 1'b0;
                pipeFreezeC = 1'b1;
                busErrorC   = 1'b1;
            end
            default: begin
                stateNext   = RUN;
                waitCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            waitCnt  <= '0;
            stallCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (!pcWriteC && (stallCnt != '1)) begin
                stallCnt <= stallCnt + 16'd1;
            end
        end
    end

    // Reset overrides the outputs combinationally, so the pipeline is held
    // from the moment reset asserts rather than from the next edge.
    always_comb begin
        bus.pcWrite    = reset & pcWriteC;
        bus.ifIdWrite  = reset & ifIdWriteC;
        bus.ifIdFlush  = reset & ifIdFlushC;
        bus.idExFlush  = reset & idExFlushC;
        bus.pipeFreeze = ~reset | pipeFreezeC;
        bus.busError   = reset & busErrorC;
        bus.ctrlState  = reset ? state : RUN;
        bus.stallCount = stallCnt;
    end

endmodule
